// File: rtl/rename_stage_pkg.sv
// Shared sizes and types for the rename stage and its alias tables.
// RENAME_CHECKPOINT_EN (optional) uses CKPT_BITS to size the branch checkpoint store.
package rename_stage_pkg;
    localparam int NUM_AREGS              = 16;
    localparam int NUM_PREGS              = 64;
    localparam int MAX_PREDICT_DEPTH_BITS = 2;
    localparam int CKPT_BITS              = MAX_PREDICT_DEPTH_BITS;
    localparam int AREG_W                 = $clog2(NUM_AREGS);
    localparam int PREG_W                 = $clog2(NUM_PREGS);
    localparam int RS_W                   = 3;

    typedef logic [AREG_W-1:0]    areg_t;
    typedef logic [PREG_W-1:0]    preg_t;
    typedef logic [CKPT_BITS-1:0] ckpt_tag_t;
    typedef logic [RS_W-1:0]      rs_station_t;
    typedef preg_t [NUM_AREGS-1:0] rat_t;

    typedef struct packed {
        areg_t       rs1;
        areg_t       rs2;
        areg_t       rd;
        logic        has_rd;
        logic        is_noop;
        rs_station_t rs_station;
        logic        is_branch;
        ckpt_tag_t   branch_tag;
    } decoded_instruction_t;

    typedef struct packed {
        decoded_instruction_t dec;
        preg_t                prs1;
        preg_t                prs2;
        preg_t                prd;
        preg_t                old_prd;
        logic                 writes_rd;
    } renamed_instruction_t;

    // rs_station 0 means the uop never reaches a station, so it has no result to rename.
    function automatic logic slot_writes(input decoded_instruction_t d);
        return !d.is_noop && (d.rs_station != '0) && d.has_rd && (d.rd != '0);
    endfunction

    function automatic rat_t rat_identity();
        rat_t r;
        for (int i = 0; i < NUM_AREGS; i++) r[i] = preg_t'(i);
        return r;
    endfunction
endpackage

// File: rtl/rename_stage_if.sv
// Decode-to-rename pair handshake plus commit and flush controls.
// RENAME_CHECKPOINT_EN adds branch_restore/restore_tag.
interface rename_stage_if;
    import rename_stage_pkg::*;

    logic                 prev_valid;
    logic                 enabled;
    logic                 next_enabled;
    logic                 next_stalled;
    logic                 clear;
    decoded_instruction_t decoded_1;
    decoded_instruction_t decoded_2;
    preg_t                preg1;
    preg_t                preg2;
    logic                 commit_valid;
    areg_t                commit_areg;
    preg_t                commit_preg;
    logic                 valid;
    logic                 stalled;
    renamed_instruction_t renamed_1;
    renamed_instruction_t renamed_2;
`ifdef RENAME_CHECKPOINT_EN
    logic                 branch_restore;
    ckpt_tag_t            restore_tag;

    modport master (
        output prev_valid, enabled, next_enabled, next_stalled, clear,
               decoded_1, decoded_2, preg1, preg2,
               commit_valid, commit_areg, commit_preg, branch_restore, restore_tag,
        input  valid, stalled, renamed_1, renamed_2
    );
    modport slave (
        input  prev_valid, enabled, next_enabled, next_stalled, clear,
               decoded_1, decoded_2, preg1, preg2,
               commit_valid, commit_areg, commit_preg, branch_restore, restore_tag,
        output valid, stalled, renamed_1, renamed_2
    );
`else
    modport master (
        output prev_valid, enabled, next_enabled, next_stalled, clear,
               decoded_1, decoded_2, preg1, preg2,
               commit_valid, commit_areg, commit_preg,
        input  valid, stalled, renamed_1, renamed_2
    );
    modport slave (
        input  prev_valid, enabled, next_enabled, next_stalled, clear,
               decoded_1, decoded_2, preg1, preg2,
               commit_valid, commit_areg, commit_preg,
        output valid, stalled, renamed_1, renamed_2
    );
`endif
endinterface

// File: rtl/rename_stage_rat.sv
// Speculative + retirement alias tables: combinational reads, two ordered writes, commit, bulk restore.
// Updates land on the next edge; no backpressure. RENAME_CHECKPOINT_EN adds per-tag checkpoints.
module reg_alias_table
    import rename_stage_pkg::*;
#(
    parameter int NUM_RD = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  areg_t [NUM_RD-1:0]      rd_areg_i,
    output preg_t [NUM_RD-1:0]      rd_preg_o,
    input  logic  [1:0]             wr_en_i,
    input  areg_t [1:0]             wr_areg_i,
    input  preg_t [1:0]             wr_preg_i,
    input  logic                    commit_vld_i,
    input  areg_t                   commit_areg_i,
    input  preg_t                   commit_preg_i,
    input  logic                    clear_i
`ifdef RENAME_CHECKPOINT_EN
    ,
    input  logic      [1:0]         save_en_i,
    input  ckpt_tag_t [1:0]         save_tag_i,
    input  logic                    restore_i,
    input  ckpt_tag_t               restore_tag_i
`endif
);
    rat_t spec_q, spec_d, retire_q, retire_d;
    rat_t after0, after1;
`ifdef RENAME_CHECKPOINT_EN
    rat_t ckpt_q [2**CKPT_BITS];
`endif

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign rd_preg_o[g] = spec_q[rd_areg_i[g]];
    end

    // after0/after1 are the table as seen after slot 1 and after both slots.
    always_comb begin
        after0 = spec_q;
        if (wr_en_i[0]) after0[wr_areg_i[0]] = wr_preg_i[0];
        after1 = after0;
        if (wr_en_i[1]) after1[wr_areg_i[1]] = wr_preg_i[1];

        retire_d = retire_q;
        if (commit_vld_i && (commit_areg_i != '0)) retire_d[commit_areg_i] = commit_preg_i;

        spec_d = after1;
`ifdef RENAME_CHECKPOINT_EN
        if (restore_i) spec_d = ckpt_q[restore_tag_i];
`endif
        if (clear_i) spec_d = retire_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spec_q   <= rat_identity();
            retire_q <= rat_identity();
        end else begin
            spec_q   <= spec_d;
            retire_q <= retire_d;
        end
    end

`ifdef RENAME_CHECKPOINT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**CKPT_BITS; i++) ckpt_q[i] <= rat_identity();
        end else begin
            if (save_en_i[0]) ckpt_q[save_tag_i[0]] <= after0;
            if (save_en_i[1]) ckpt_q[save_tag_i[1]] <= after1;
        end
    end
`endif
endmodule

// File: rtl/rename_stage.sv
// Rename stage: maps a decoded pair onto pregs with in-pair bypass; 1-cycle latency, enabled=0 freezes all.
// stalled = prev_valid && next_stalled. RENAME_CHECKPOINT_EN adds branch checkpoint/restore.
module rename_stage
    import rename_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    rename_stage_if.slave io
);
    decoded_instruction_t d1, d2;
    logic                 w1, w2, fire, restore;
    preg_t                prd1, prd2;
    areg_t [5:0]          rd_areg;
    preg_t [5:0]          rd_preg;
    renamed_instruction_t ren1, ren2;
    renamed_instruction_t ren1_q, ren1_d, ren2_q, ren2_d;
    logic                 valid_q, valid_d;

    assign d1   = io.decoded_1;
    assign d2   = io.decoded_2;
    assign w1   = slot_writes(d1);
    assign w2   = slot_writes(d2);
    assign prd1 = io.preg1;
    assign prd2 = w1 ? io.preg2 : io.preg1;
    assign fire = io.enabled && io.prev_valid && !io.clear && !restore;

    assign rd_areg = {d2.rd, d1.rd, d2.rs2, d2.rs1, d1.rs2, d1.rs1};

`ifdef RENAME_CHECKPOINT_EN
    logic      [1:0] save_en;
    ckpt_tag_t [1:0] save_tag;
    assign restore  = io.branch_restore;
    assign save_en  = {fire && d2.is_branch, fire && d1.is_branch};
    assign save_tag = {d2.branch_tag, d1.branch_tag};
`else
    assign restore  = 1'b0;
`endif

    // Non-writing slots report prd/old_prd as 0.
    always_comb begin
        ren1           = '0;
        ren1.dec       = d1;
        ren1.writes_rd = w1;
        ren1.prs1      = (d1.rs1 == '0) ? '0 : rd_preg[0];
        ren1.prs2      = (d1.rs2 == '0) ? '0 : rd_preg[1];
        if (w1) begin
            ren1.prd     = prd1;
            ren1.old_prd = rd_preg[4];
        end

        ren2           = '0;
        ren2.dec       = d2;
        ren2.writes_rd = w2;
        ren2.prs1      = (d2.rs1 == '0) ? '0 : (w1 && d2.rs1 == d1.rd) ? prd1 : rd_preg[2];
        ren2.prs2      = (d2.rs2 == '0) ? '0 : (w1 && d2.rs2 == d1.rd) ? prd1 : rd_preg[3];
        if (w2) begin
            ren2.prd     = prd2;
            ren2.old_prd = (w1 && d2.rd == d1.rd) ? prd1 : rd_preg[5];
        end
    end

    always_comb begin
        valid_d = valid_q;
        ren1_d  = ren1_q;
        ren2_d  = ren2_q;
        if (io.clear || restore) begin
            valid_d = 1'b0;
        end else if (io.enabled) begin
            if (io.prev_valid) begin
                valid_d = 1'b1;
                ren1_d  = ren1;
                ren2_d  = ren2;
            end else if (io.next_enabled) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ren1_q  <= '0;
            ren2_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ren1_q  <= ren1_d;
            ren2_q  <= ren2_d;
        end
    end

    reg_alias_table #(.NUM_RD(6)) u_rat (
        .clk           (clk),
        .reset         (reset),
        .rd_areg_i     (rd_areg),
        .rd_preg_o     (rd_preg),
        .wr_en_i       ({fire && w2, fire && w1}),
        .wr_areg_i     ({d2.rd, d1.rd}),
        .wr_preg_i     ({prd2, prd1}),
        .commit_vld_i  (io.commit_valid),
        .commit_areg_i (io.commit_areg),
        .commit_preg_i (io.commit_preg),
        .clear_i       (io.clear)
`ifdef RENAME_CHECKPOINT_EN
        ,
        .save_en_i     (save_en),
        .save_tag_i    (save_tag),
        .restore_i     (restore),
        .restore_tag_i (io.restore_tag)
`endif
    );

    assign io.valid     = valid_q;
    assign io.renamed_1 = ren1_q;
    assign io.renamed_2 = ren2_q;
    assign io.stalled   = io.prev_valid && io.next_stalled;
endmodule
